bouncing_box_gen: RTL and testbench

Pixel-source stage between the VGA timing generator and the VGA pins. Consumes the 25 MHz timing (CounterX, CounterY, inDisplayArea, raw syncs) and produces a 3-bit colour stream that draws a solid box on a black background. The box moves once per frame and bounces off the active-area edges. Its colour advances on every bounce. Syncs are delayed so they stay aligned with the pixel data.

---
 rtl/bouncing_box_pkg.sv | 18 +
 rtl/bouncing_box_gen_axis.sv | 48 ++++
 rtl/bouncing_box_gen.sv | 118 +++++++++++
 tb/tb_bouncing_box_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bouncing_box_pkg.sv
// Shared defaults, colour constants and colour-advance helper for the bouncing box generator.
package bouncing_box_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_BOX_SIZE = 32;
  localparam int DEF_STEP     = 2;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_RESET = 3'b100;

  // Black is never a box colour, so 7 wraps straight to 1.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/bouncing_box_gen_axis.sv
// One axis of box motion: position, direction and edge bounce, advanced when update is high.
module box_axis_mover
  import bouncing_box_pkg::*;
#(
  parameter int LIMIT = DEF_H_ACTIVE,
  parameter int SIZE  = DEF_BOX_SIZE,
  parameter int STEP  = DEF_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] MAX    = 11'(LIMIT - SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic        dir;
  logic [10:0] sum;
  logic        hit_hi;
  logic        hit_lo;

  assign sum    = {1'b0, pos} + STEP11;
  assign hit_hi = dir && (sum > MAX);
  assign hit_lo = !dir && ({1'b0, pos} < STEP11);
  assign bounce = hit_hi || hit_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= 10'd0;
      dir <= 1'b1;
    end else if (update) begin
      if (hit_hi) begin
        pos <= MAX[9:0];
        dir <= 1'b0;
      end else if (hit_lo) begin
        pos <= 10'd0;
        dir <= 1'b1;
      end else if (dir) begin
        pos <= sum[9:0];
      end else begin
        pos <= pos - STEP11[9:0];
      end
    end
  end

endmodule

// File: rtl/bouncing_box_gen.sv
// Draws a bouncing solid box over black with a 2-stage pixel/sync pipeline.
// Optional white active-area border when BOUNCE_BORDER_EN is defined.
module bouncing_box_gen
  import bouncing_box_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BOX_SIZE = DEF_BOX_SIZE,
  parameter int STEP     = DEF_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       freeze,
  output logic [2:0] pixel,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick
);

  logic [9:0]  box_x, box_y;
  logic        bounce_x, bounce_y;
  logic [2:0]  colour;
  logic        boundary, update;
  logic [10:0] x_end, y_end;
  logic        in_box;
  logic        hit_s1, de_s1, hs_s1, vs_s1;

  // Start of vertical blanking: new position is in place before the next visible line.
  assign boundary = (CounterY == 10'(V_ACTIVE)) && (CounterX == 10'd0);
  assign update   = boundary && !freeze;

  box_axis_mover #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_x (
    .clk(clk), .rst_n(rst_n), .update(update), .pos(box_x), .bounce(bounce_x)
  );

  box_axis_mover #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_y (
    .clk(clk), .rst_n(rst_n), .update(update), .pos(box_y), .bounce(bounce_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      colour     <= COL_RESET;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= update;
      if (update && (bounce_x || bounce_y))
        colour <= next_colour(colour);
    end
  end

  assign x_end  = {1'b0, box_x} + 11'(BOX_SIZE);
  assign y_end  = {1'b0, box_y} + 11'(BOX_SIZE);
  assign in_box = (CounterX >= box_x) && ({1'b0, CounterX} < x_end) &&
                  (CounterY >= box_y) && ({1'b0, CounterY} < y_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_s1 <= 1'b0;
      de_s1  <= 1'b0;
      hs_s1  <= 1'b1;
      vs_s1  <= 1'b1;
    end else begin
      hit_s1 <= in_box;
      de_s1  <= inDisplayArea;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
    end
  end

`ifdef BOUNCE_BORDER_EN
  logic border_s1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      border_s1 <= 1'b0;
    else
      border_s1 <= (CounterX == 10'd0) || (CounterX == 10'(H_ACTIVE - 1)) ||
                   (CounterY == 10'd0) || (CounterY == 10'(V_ACTIVE - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel     <= COL_BLACK;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      if (!de_s1)
        pixel <= COL_BLACK;
      else if (border_s1)
        pixel <= COL_WHITE;
      else if (hit_s1)
        pixel <= colour;
      else
        pixel <= COL_BLACK;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel     <= COL_BLACK;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      pixel     <= (de_s1 && hit_s1) ? colour : COL_BLACK;
    end
  end
`endif

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Randomized self-checking bench for bouncing_box_gen (full-size and 64x64 instances).
module tb_bouncing_box_gen;
  import bouncing_box_pkg::*;

  localparam int H = 640, V = 480, SZ = 32, ST = 2;
  localparam int H2 = 64, V2 = 64;

  typedef struct packed { int x; int y; int dx; int dy; int col; } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [9:0] cx, cy, cx2, cy2;
  logic       de, de2, hs, vs, frz;
  logic [2:0] pix, pix2;
  logic       hso, vso, hso2, vso2, tick, tick2;

  bouncing_box_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(SZ), .STEP(ST)) dut (
    .clk(clk), .rst_n(rst_n), .CounterX(cx), .CounterY(cy), .inDisplayArea(de),
    .hsync_in(hs), .vsync_in(vs), .freeze(frz), .pixel(pix), .hsync_out(hso),
    .vsync_out(vso), .frame_tick(tick)
  );

  bouncing_box_gen #(.H_ACTIVE(H2), .V_ACTIVE(V2), .BOX_SIZE(SZ), .STEP(ST)) dut2 (
    .clk(clk), .rst_n(rst_n), .CounterX(cx2), .CounterY(cy2), .inDisplayArea(de2),
    .hsync_in(hs), .vsync_in(vs), .freeze(frz), .pixel(pix2), .hsync_out(hso2),
    .vsync_out(vso2), .frame_tick(tick2)
  );

  int   checks = 0, errors = 0;
  mdl_t m1, m2;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.x = 0; m.y = 0; m.dx = 1; m.dy = 1; m.col = 4;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int hmax, int vmax);
    int p[2], d[2], mx[2];
    bit any;
    p[0] = m.x; p[1] = m.y; d[0] = m.dx; d[1] = m.dy; mx[0] = hmax; mx[1] = vmax;
    any = 0;
    for (int i = 0; i < 2; i++) begin
      if (d[i] == 1 && p[i] + ST > mx[i]) begin p[i] = mx[i]; d[i] = 0; any = 1; end
      else if (d[i] == 0 && p[i] < ST)    begin p[i] = 0;     d[i] = 1; any = 1; end
      else p[i] = (d[i] == 1) ? p[i] + ST : p[i] - ST;
    end
    m.x = p[0]; m.y = p[1]; m.dx = d[0]; m.dy = d[1];
    if (any) m.col = (m.col == 7) ? 1 : m.col + 1;
    return m;
  endfunction

  function automatic int exp_pix(mdl_t m, int x, int y, bit d, int hw, int vw);
    if (!d) return 0;
`ifdef BOUNCE_BORDER_EN
    if (x == 0 || x == hw - 1 || y == 0 || y == vw - 1) return 7;
`endif
    if (x >= m.x && x < m.x + SZ && y >= m.y && y < m.y + SZ) return m.col;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle reference: expectation for the input seen at edge k appears after edge k+1.
  int p1p, p1h, p1v, p2p, p2h, p2v;
  int o1p, o1h, o1v, o2p, o2h, o2v;
  bit t1, t2;

  always @(posedge clk) begin
    if (!rst_n) begin
      m1 = mdl_reset(); m2 = mdl_reset();
      o1p = 0; o1h = 1; o1v = 1; o2p = 0; o2h = 1; o2v = 1;
      p1p = 0; p1h = 1; p1v = 1; p2p = 0; p2h = 1; p2v = 1;
      t1 = 0; t2 = 0;
    end else begin
      o1p = p1p; o1h = p1h; o1v = p1v; o2p = p2p; o2h = p2h; o2v = p2v;
      p1p = exp_pix(m1, int'(cx), int'(cy), de, H, V);
      p2p = exp_pix(m2, int'(cx2), int'(cy2), de2, H2, V2);
      p1h = hs; p1v = vs; p2h = hs; p2v = vs;
      t1 = (int'(cy) == V && cx == 0 && !frz);
      t2 = (int'(cy2) == V2 && cx2 == 0 && !frz);
      if (t1) m1 = mdl_step(m1, H - SZ, V - SZ);
      if (t2) m2 = mdl_step(m2, H2 - SZ, V2 - SZ);
    end
    #1;
    chk("pixel", pix, o1p);
    chk("hsync_out", hso, o1h);
    chk("vsync_out", vso, o1v);
    chk("frame_tick", tick, t1);
    chk("pixel2", pix2, o2p);
    chk("sync2", {hso2, vso2}, {o2h[0], o2v[0]});
    chk("frame_tick2", tick2, t2);
  end

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        cx = 10'($urandom_range(0, 799));
        cy = 10'($urandom_range(0, 524));
      end else begin
        cx = 10'(m1.x + $urandom_range(0, 40));
        cy = 10'(m1.y + $urandom_range(0, 40));
      end
      if (int'(cy) == V && cx == 0) cx = 10'd1;
      de  = (int'(cx) < H) && (int'(cy) < V);
      cx2 = 10'($urandom_range(0, 80));
      cy2 = 10'($urandom_range(0, 80));
      if (int'(cy2) == V2 && cx2 == 0) cx2 = 10'd1;
      de2 = (int'(cx2) < H2) && (int'(cy2) < V2);
      hs  = 1'($urandom);
      vs  = 1'($urandom);
    end
  endtask

  task automatic boundary();
    @(negedge clk);
    cx = 10'd0; cy = 10'(V); de = 1'b0;
  endtask

  task automatic boundary2();
    @(negedge clk);
    cx2 = 10'd0; cy2 = 10'(V2); de2 = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input int req);
    @(negedge clk);
    cx = 10'(x); cy = 10'(y); de = 1'b1;
    @(negedge clk);
    de = 1'b0;
    @(posedge clk);
    #2 chk(name, pix, req);
  endtask

  task automatic probe2(input string name, input int x, input int y, input int req);
    @(negedge clk);
    cx2 = 10'(x); cy2 = 10'(y); de2 = 1'b1;
    @(negedge clk);
    de2 = 1'b0;
    @(posedge clk);
    #2 chk(name, pix2, req);
  endtask

  initial begin
    cx = 0; cy = 0; de = 0; cx2 = 0; cy2 = 0; de2 = 0; hs = 1; vs = 1; frz = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    probe("first_frame_box", 5, 5, 3'b100);
    probe("first_frame_corner", 31, 31, 3'b100);
    probe("first_frame_outside", 32, 5, 0);
    rand_cycles(60);

    boundary();
    rand_cycles(4);
    probe("moved_old_corner", 1, 1, 0);
    probe("moved_new_corner", 2, 2, 3'b100);
    probe("moved_far_corner", 33, 33, 3'b100);

    for (int k = 2; k <= 225; k++) begin rand_cycles(8); boundary(); end
    rand_cycles(4);
    chk("model_y_clamp", m1.y, 448);
    chk("model_dir_y", m1.dy, 0);
    chk("model_col_225", m1.col, 5);
    probe("y_bounce_inside", 460, 460, 3'b101);
    probe("y_bounce_above", 460, 447, 0);

    for (int k = 226; k <= 305; k++) begin rand_cycles(8); boundary(); end
    rand_cycles(4);
    chk("model_x_clamp", m1.x, 608);
    chk("model_col_305", m1.col, 6);
    probe("x_bounce_inside", 610, 290, 3'b110);
    probe("x_bounce_edge", 639, 319, 3'b110);

    frz = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_cycles(6); boundary(); end
    rand_cycles(4);
    frz = 1'b0;
    probe("freeze_held", 610, 290, 3'b110);
    probe("freeze_held_edge", 609, 287, 0);

    for (int k = 0; k < 60; k++) begin
      frz = 1'($urandom);
      rand_cycles(6);
      boundary();
    end
    frz = 1'b0;
    rand_cycles(30);

    @(negedge clk);
    cx = 10'd200; cy = 10'd100; de = 1'b1; rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rand_cycles(10);
    chk("reset_model_pos", m1.x + m1.y, 0);
    probe("reset_box", 5, 5, 3'b100);
    probe("reset_outside", 40, 40, 0);

    for (int k = 0; k < 17; k++) begin rand_cycles(5); boundary2(); end
    rand_cycles(4);
    chk("small_model_col", m2.col, 5);
    chk("small_model_pos", m2.x * 100 + m2.y, 3232);
    probe2("small_both_bounce", 40, 40, 3'b101);

    rand_cycles(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
